sm_imem_loader: RTL and testbench

//  Instruction memory and boot loader that sits directly upstream of sm_cpu.

---
 rtl/sm_imem_loader_pkg.sv | 19 +
 rtl/sm_imem_loader_if.sv | 10 +
 rtl/sm_imem_ram.sv | 24 ++
 rtl/sm_imem_loader.sv | 149 ++++++++++++++
 tb/tb_sm_imem_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_imem_loader_pkg.sv
// rtl/sm_imem_loader_pkg.sv - shared loader state encoding and word packing helper
// State values match the LDR_* defines used on the sm_cpu side.
package sm_imem_loader_pkg;

  typedef enum logic [1:0] {
    LDR_LEN0 = 2'd0,
    LDR_LEN1 = 2'd1,
    LDR_DATA = 2'd2,
    LDR_RUN  = 2'd3
  } ldr_state_e;

  localparam int unsigned LEN_WIDTH = 16;

  // Byte 3 arrives last; bytes 0..2 are already held little-endian in the low 24 bits.
  function automatic logic [31:0] pack_word(input logic [7:0] b3, input logic [23:0] lo);
    return {b3, lo};
  endfunction

endpackage

// File: rtl/sm_imem_loader_if.sv
// rtl/sm_imem_loader_if.sv - program byte stream into the loader
// The source drives data/valid; the loader answers with ready.
interface sm_imem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sm_imem_ram.sv
// rtl/sm_imem_ram.sv - instruction word RAM, one synchronous write port, one async read port
module sm_imem_ram #(
  parameter int    ADDR_WIDTH = 6,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [31:0]           wd_i,
  input  logic [ADDR_WIDTH-1:0] ra_i,
  output logic [31:0]           rd_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/sm_imem_loader.sv
// rtl/sm_imem_loader.sv - boot loader and instruction memory upstream of sm_cpu
// Loads a length-prefixed little-endian word stream, holds the CPU in reset meanwhile.
module sm_imem_loader
  import sm_imem_loader_pkg::*;
#(
  parameter int    ADDR_WIDTH = 6,
  parameter string INIT_FILE  = "",
  parameter bit    BOOT_RUN   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  sm_imem_loader_if.slave     rx,
  input  logic                load_req,
  input  logic [31:0]         imAddr,
  output logic [31:0]         imData,
  output logic                cpu_rst_n,
  output logic                load_done,
  output logic                ovf
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam ldr_state_e RESET_STATE = BOOT_RUN ? LDR_RUN : LDR_LEN0;

  ldr_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] n_q, n_d;
  logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [1:0]           bidx_q, bidx_d;
  logic [23:0]          sh_q, sh_d;
  logic [ADDR_WIDTH:0]  ptr_q, ptr_d;
  logic                 ovf_q, ovf_d;
  logic                 cpu_rst_n_q;
  logic                 load_done_q;

  logic                 accept;
  logic                 in_range;
  logic                 we;
  logic [31:0]          wd;
  logic [31:0]          rd;
  logic [LEN_WIDTH-1:0] wcnt_inc;

  assign rx.rx_ready = (state_q != LDR_RUN);
  assign accept      = rx.rx_valid & rx.rx_ready;
  // Pointer stops at DEPTH, so its top bit marks every later word as out of range.
  assign in_range    = ~ptr_q[ADDR_WIDTH];
  assign wcnt_inc    = wcnt_q + LEN_WIDTH'(1);
  assign wd          = pack_word(rx.rx_data, sh_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    case (state_q)
      LDR_LEN0: begin
        if (accept) begin
          n_d[7:0] = rx.rx_data;
          state_d  = LDR_LEN1;
        end
      end
      LDR_LEN1: begin
        if (accept) begin
          n_d[15:8] = rx.rx_data;
          if ({rx.rx_data, n_q[7:0]} == '0) begin
            state_d = LDR_RUN;
          end else begin
            ptr_d   = '0;
            bidx_d  = '0;
            wcnt_d  = '0;
            state_d = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        if (accept) begin
          if (bidx_q == 2'd3) begin
            we     = in_range;
            bidx_d = '0;
            wcnt_d = wcnt_inc;
            if (in_range) begin
              ptr_d = ptr_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
            if (wcnt_inc == n_q) begin
              state_d = LDR_RUN;
            end
          end else begin
            sh_d   = {rx.rx_data, sh_q[23:8]};
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      LDR_RUN: begin
        if (load_req) begin
          state_d = LDR_LEN0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      n_q         <= '0;
      wcnt_q      <= '0;
      bidx_q      <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      cpu_rst_n_q <= BOOT_RUN;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      bidx_q      <= bidx_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      ovf_q       <= ovf_d;
      cpu_rst_n_q <= (state_d == LDR_RUN);
      load_done_q <= (state_d == LDR_RUN) && (state_q != LDR_RUN);
    end
  end

  sm_imem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk (clk),
    .we_i(we),
    .wa_i(ptr_q[ADDR_WIDTH-1:0]),
    .wd_i(wd),
    .ra_i(imAddr[ADDR_WIDTH-1:0]),
    .rd_o(rd)
  );

  // Full 32-bit compare: addresses past DEPTH read as NOP instead of aliasing.
  assign imData    = (imAddr < 32'(DEPTH)) ? rd : 32'h0;
  assign cpu_rst_n = cpu_rst_n_q;
  assign load_done = load_done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// tb/tb_sm_imem_loader.sv - randomized self-checking bench for sm_imem_loader
// A byte-count model predicts flags and RAM; a boot-run instance covers BOOT_RUN=1 reset.
module tb_sm_imem_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_req;
  logic [31:0] imAddr, imData;
  logic        cpu_rst_n, load_done, ovf;
  logic        hold;
  logic [31:0] dir_addr, rnd_addr;

  logic        load_req_b;
  logic [31:0] imAddr_b, imData_b;
  logic        cpu_rst_n_b, load_done_b, ovf_b;

  sm_imem_loader_if bus ();
  sm_imem_loader_if bus_b ();

  sm_imem_loader #(.ADDR_WIDTH(AW), .INIT_FILE(""), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .rx(bus.slave), .load_req(load_req), .imAddr(imAddr),
    .imData(imData), .cpu_rst_n(cpu_rst_n), .load_done(load_done), .ovf(ovf)
  );

  sm_imem_loader #(.ADDR_WIDTH(2), .INIT_FILE(""), .BOOT_RUN(1'b1)) dut_boot (
    .clk(clk), .rst(rst), .rx(bus_b.slave), .load_req(load_req_b), .imAddr(imAddr_b),
    .imData(imData_b), .cpu_rst_n(cpu_rst_n_b), .load_done(load_done_b), .ovf(ovf_b)
  );

  assign imAddr = hold ? dir_addr : rnd_addr;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted bytes of the current load.
  bit          m_loading;
  int          m_nb;
  logic [15:0] m_n;
  logic [7:0]  m_b [4];
  logic [31:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  bit          m_ovf, m_done;
  int          k, w;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_loading = 1'b1;
      m_nb      = 0;
      m_ovf     = 1'b0;
    end else if (!m_loading) begin
      if (load_req) begin
        m_loading = 1'b1;
        m_nb      = 0;
        m_ovf     = 1'b0;
      end
    end else if (bus.rx_valid) begin
      if (m_nb == 0) begin
        m_n[7:0] = bus.rx_data;
      end else if (m_nb == 1) begin
        m_n[15:8] = bus.rx_data;
        if (m_n == 16'd0) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end else begin
        k = m_nb - 2;
        m_b[k % 4] = bus.rx_data;
        if (k % 4 == 3) begin
          w = k / 4;
          if (w < DEPTH) begin
            m_ram[w]   = {m_b[3], m_b[2], m_b[1], m_b[0]};
            m_known[w] = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          if (w + 1 == int'(m_n)) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end
      m_nb++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_ready", {31'd0, bus.rx_ready}, {31'd0, m_loading});
      check("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, !m_loading});
      check("load_done", {31'd0, load_done}, {31'd0, m_done});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (imAddr >= DEPTH) check("imData_oob", imData, 32'h0);
      else if (m_known[imAddr[AW-1:0]]) check("imData", imData, m_ram[imAddr[AW-1:0]]);
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 1));
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task send_byte(input logic [7:0] b, input int gap, input bit noise);
    int  t;
    bit  acc;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      load_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    load_req     = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 40) begin
      @(negedge clk);
      acc = bus.rx_ready;
      tick();
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no ready expected ready for byte %h", b);
    end
    bus.rx_valid = 1'b0;
  endtask

  logic [31:0] pw [16];

  task send_load(input int n, input int gmin, input int gmax, input bit noise);
    send_byte(8'(n), $urandom_range(gmin, gmax), noise);
    send_byte(8'(n >> 8), $urandom_range(gmin, gmax), noise);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(8'(pw[i] >> (8 * j)), $urandom_range(gmin, gmax), noise);
      end
    end
  endtask

  task peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    dir_addr = a;
    hold     = 1'b1;
    #1;
    check(nm, imData, exp);
    hold = 1'b0;
  endtask

  task pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("req_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("req_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; hold = 1'b0; dir_addr = '0; rnd_addr = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    bus_b.rx_valid = 1'b0; bus_b.rx_data = '0; load_req_b = 1'b0; imAddr_b = 32'd4;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("boot_cpu_rst_n", {31'd0, cpu_rst_n_b}, 32'd1);
    check("boot_rx_ready", {31'd0, bus_b.rx_ready}, 32'd0);
    check("boot_imData_oob", imData_b, 32'h0);

    // Directed stream, no gaps.
    pw[0] = 32'h12345678; pw[1] = 32'h87654321;
    send_load(2, 0, 0, 1'b0);
    check("t1_load_done", {31'd0, load_done}, 32'd1);
    check("t1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    peek("t1_ram0", 32'd0, 32'h12345678);
    peek("t1_ram1", 32'd1, 32'h87654321);
    tick();
    check("t1_done_pulse", {31'd0, load_done}, 32'd0);

    // Same stream with 3 idle cycles before every byte, load_req noise in gaps.
    pulse_load_req();
    send_load(2, 3, 3, 1'b1);
    check("t2_load_done", {31'd0, load_done}, 32'd1);
    peek("t2_ram1", 32'd1, 32'h87654321);

    // Zero-length program.
    pulse_load_req();
    send_load(0, 0, 1, 1'b0);
    check("t3_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t3_ovf", {31'd0, ovf}, 32'd0);
    peek("t3_ram0", 32'd0, 32'h12345678);

    // Overflow: 10 words into 8.
    pulse_load_req();
    for (int i = 0; i < 10; i++) pw[i] = 32'hA000_0000 + 32'(i);
    send_load(10, 0, 1, 1'b0);
    check("t4_ovf", {31'd0, ovf}, 32'd1);
    check("t4_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    peek("t4_ram7", 32'd7, 32'hA000_0007);
    peek("t4_oob8", 32'd8, 32'h0);
    peek("t4_oob_hi", 32'h8000_0003, 32'h0);

    // Reset after 3 bytes of word 1, then a fresh 1-word load.
    pulse_load_req();
    check("t5_ovf_clr", {31'd0, ovf}, 32'd0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(8'(32'hCAFEF00D >> (8 * j)), 0, 1'b0);
    for (int j = 0; j < 3; j++) send_byte(8'h5A, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("t5_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    peek("t5_ram1_kept", 32'd1, 32'hA000_0001);
    pw[0] = 32'hDEADBEEF;
    send_load(1, 0, 2, 1'b1);
    check("t5_load_done", {31'd0, load_done}, 32'd1);
    peek("t5_ram0", 32'd0, 32'hDEADBEEF);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      int n;
      pulse_load_req();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) pw[i] = $urandom;
      send_load(n, 0, 3, 1'b1);
      repeat ($urandom_range(1, 4)) tick();
    end

    // Boot-run instance reload request.
    load_req_b = 1'b1;
    tick();
    load_req_b = 1'b0;
    check("boot_req_rx_ready", {31'd0, bus_b.rx_ready}, 32'd1);
    check("boot_req_cpu_rst_n", {31'd0, cpu_rst_n_b}, 32'd0);
    check("boot_load_done", {31'd0, load_done_b}, 32'd0);
    check("boot_ovf", {31'd0, ovf_b}, 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
